// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - I/D requester, dmem and owner signals around the dmem port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IWE;
  logic [DW-1:0] IWD;
  logic          IReady;
  logic [DW-1:0] IRD;

  logic          DReq;
  logic [AW-1:0] DAddr;
  logic          DWE;
  logic [DW-1:0] DWD;
  logic          DReady;
  logic [DW-1:0] DRD;

  logic          MReq;
  logic [AW-1:0] MAddr;
  logic          MWE;
  logic [DW-1:0] MWD;
  logic          MReady;
  logic [DW-1:0] MRD;

  logic [1:0]    Owner;

  modport slave (
    input  IReq, IAddr, IWE, IWD,
    output IReady, IRD,
    input  DReq, DAddr, DWE, DWD,
    output DReady, DRD,
    output MReq, MAddr, MWE, MWD,
    input  MReady, MRD,
    output Owner
  );

  modport master (
    output IReq, IAddr, IWE, IWD,
    input  IReady, IRD,
    output DReq, DAddr, DWE, DWD,
    input  DReady, DRD,
    input  MReq, MAddr, MWE, MWD,
    output MReady, MRD,
    input  Owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin I/D arbiter for the shared dmem port with burst hold
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int            BW         = $clog2(BURST_MAX + 1);
  localparam logic [BW:0]   BEAT_LIMIT = (BW + 1)'(BURST_MAX);
  localparam logic [BW:0]   ONE        = (BW + 1)'(1);

  state_t        state, state_n;
  logic          last_d, last_d_n;
  logic [BW-1:0] beats, beats_n;
  logic [BW:0]   beats_inc;
  logic          own_req, other_req;

  logic          m_req, m_we, i_ready, d_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [1:0]    owner;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state  <= IDLE;
      last_d <= 1'b0;
      beats  <= '0;
    end else begin
      state  <= state_n;
      last_d <= last_d_n;
      beats  <= beats_n;
    end
  end

  always_comb begin
    state_n   = state;
    last_d_n  = last_d;
    beats_n   = beats;
    own_req   = 1'b0;
    other_req = 1'b0;
    beats_inc = {1'b0, beats} + ONE;
    case (state)
      IDLE: begin
        beats_n = '0;
        // On contention the side that did not own the port last wins.
        if (bus.IReq && bus.DReq) begin
          state_n = last_d ? BUSY_I : BUSY_D;
        end else if (bus.IReq) begin
          state_n = BUSY_I;
        end else if (bus.DReq) begin
          state_n = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        own_req   = (state == BUSY_I) ? bus.IReq : bus.DReq;
        other_req = (state == BUSY_I) ? bus.DReq : bus.IReq;
        if (bus.MReady) begin
          beats_n = (beats_inc >= BEAT_LIMIT) ? BEAT_LIMIT[BW-1:0] : beats_inc[BW-1:0];
          // Preemption only happens on a completed beat, never mid-beat.
          if ((beats_inc >= BEAT_LIMIT) && other_req) begin
            state_n  = IDLE;
            last_d_n = (state == BUSY_D);
          end
        end else if (!own_req) begin
          state_n  = IDLE;
          last_d_n = (state == BUSY_D);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    m_req   = 1'b0;
    m_addr  = '0;
    m_we    = 1'b0;
    m_wd    = '0;
    i_ready = 1'b0;
    d_ready = 1'b0;
    owner   = 2'b00;
    // Held in reset the port looks idle even if state still shows an owner.
    if (!Reset) begin
      case (state)
        BUSY_I: begin
          m_req   = bus.IReq;
          m_addr  = bus.IAddr;
          m_we    = bus.IWE;
          m_wd    = bus.IWD;
          i_ready = bus.MReady;
          owner   = 2'b01;
        end
        BUSY_D: begin
          m_req   = bus.DReq;
          m_addr  = bus.DAddr;
          m_we    = bus.DWE;
          m_wd    = bus.DWD;
          d_ready = bus.MReady;
          owner   = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign bus.MReq   = m_req;
  assign bus.MAddr  = m_addr;
  assign bus.MWE    = m_we;
  assign bus.MWD    = m_wd;
  assign bus.IReady = i_ready;
  assign bus.DReady = d_ready;
  assign bus.Owner  = owner;
  assign bus.IRD    = bus.MRD;
  assign bus.DRD    = bus.MRD;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BURST_MAX = 4;

  logic CLK = 1'b0;
  logic Reset = 1'b1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // requester and memory stimulus state
  int            i_left = 0, i_ntx = 0, i_blen = 1;
  logic          i_gap = 1'b0, i_we = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_wd = '0;
  int            d_left = 0, d_ntx = 0, d_blen = 1;
  logic          d_gap = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wd = '0;
  int            mem_lat = 0, wait_cnt = 0, cyc = 0;
  logic          mem_force = 1'b0;
  logic [DW-1:0] rd_val = '0;

  assign bus.IReq   = (i_left > 0);
  assign bus.IAddr  = i_addr;
  assign bus.IWE    = i_we;
  assign bus.IWD    = i_wd;
  assign bus.DReq   = (d_left > 0);
  assign bus.DAddr  = d_addr;
  assign bus.DWE    = d_we;
  assign bus.DWD    = d_wd;
  assign bus.MReady = mem_force | (bus.MReq & (wait_cnt >= mem_lat));
  assign bus.MRD    = rd_val;

  // values seen just before each rising edge
  logic c_reset = 1'b1, c_ireq = 1'b0, c_dreq = 1'b0, c_mready = 1'b0, c_mreq = 1'b0;
  logic c_iready = 1'b0, c_dready = 1'b0;

  // behavioural model: who owns the port, beats served, who was released last
  int   m_owner = 0;
  int   m_beats = 0;
  logic m_last_d = 1'b0;

  int            trace[$];
  logic [AW-1:0] atrace[$];
  int            i_rdy_n = 0, d_rdy_n = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  always @(posedge CLK) begin
    logic own, other;
    if (c_reset) begin
      m_owner = 0; m_beats = 0; m_last_d = 1'b0;
    end else if (m_owner == 0) begin
      m_beats = 0;
      if (c_ireq && c_dreq) m_owner = m_last_d ? 1 : 2;
      else if (c_ireq) m_owner = 1;
      else if (c_dreq) m_owner = 2;
    end else begin
      own   = (m_owner == 1) ? c_ireq : c_dreq;
      other = (m_owner == 1) ? c_dreq : c_ireq;
      if (c_mready) begin
        if (m_beats + 1 >= BURST_MAX && other) begin
          m_last_d = (m_owner == 2);
          m_owner  = 0;
        end
        m_beats = (m_beats + 1 > BURST_MAX) ? BURST_MAX : m_beats + 1;
      end else if (!own) begin
        m_last_d = (m_owner == 2);
        m_owner  = 0;
      end
    end
  end

  always @(negedge CLK) begin : cmp
    logic [1:0]    e_owner;
    logic          e_mreq, e_mwe, e_ir, e_dr;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwd;
    e_owner = 2'b00; e_mreq = 1'b0; e_mwe = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
    e_maddr = '0; e_mwd = '0;
    if (!Reset && m_owner == 1) begin
      e_owner = 2'b01; e_mreq = i_left > 0; e_maddr = i_addr; e_mwe = i_we; e_mwd = i_wd;
      e_ir = bus.MReady;
    end else if (!Reset && m_owner == 2) begin
      e_owner = 2'b10; e_mreq = d_left > 0; e_maddr = d_addr; e_mwe = d_we; e_mwd = d_wd;
      e_dr = bus.MReady;
    end
    check("owner",  bus.Owner,  e_owner);
    check("mreq",   bus.MReq,   e_mreq);
    check("maddr",  bus.MAddr,  e_maddr);
    check("mwe",    bus.MWE,    e_mwe);
    check("mwd",    bus.MWD,    e_mwd);
    check("iready", bus.IReady, e_ir);
    check("dready", bus.DReady, e_dr);
    check("ird",    bus.IRD,    rd_val);
    check("drd",    bus.DRD,    rd_val);
    trace.push_back(int'(bus.Owner));
    atrace.push_back(bus.MAddr);
    if (bus.IReady) i_rdy_n++;
    if (bus.DReady) d_rdy_n++;
    c_reset  = Reset;
    c_ireq   = bus.IReq;
    c_dreq   = bus.DReq;
    c_mready = bus.MReady;
    c_mreq   = bus.MReq;
    c_iready = bus.IReady;
    c_dready = bus.DReady;
  end

  // requesters hold each beat until Ready, then advance; 1-cycle gap between transactions
  always @(posedge CLK) begin
    #1;
    cyc++;
    rd_val = 32'hA500_0000 + DW'(cyc);
    if (c_mready) wait_cnt = 0;
    else if (c_mreq) wait_cnt++;
    else wait_cnt = 0;
    if (!c_reset) begin
      if (c_iready && i_left > 0) begin
        i_left--; i_addr++; i_wd++;
        if (i_left == 0) i_gap = 1'b1;
      end else if (i_gap) begin
        i_gap = 1'b0;
        if (i_ntx > 0) begin i_ntx--; i_left = i_blen; end
      end
      if (c_dready && d_left > 0) begin
        d_left--; d_addr++; d_wd++;
        if (d_left == 0) d_gap = 1'b1;
      end else if (d_gap) begin
        d_gap = 1'b0;
        if (d_ntx > 0) begin d_ntx--; d_left = d_blen; end
      end
    end
  end

  task automatic to_drive();
    @(posedge CLK);
    #2;
  endtask

  task automatic req_i(input int blen, input int ntx, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] wd);
    i_blen = blen; i_ntx = ntx - 1; i_left = blen; i_gap = 1'b0;
    i_addr = a; i_we = we; i_wd = wd;
  endtask

  task automatic req_d(input int blen, input int ntx, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] wd);
    d_blen = blen; d_ntx = ntx - 1; d_left = blen; d_gap = 1'b0;
    d_addr = a; d_we = we; d_wd = wd;
  endtask

  task automatic clear_reqs();
    i_left = 0; i_ntx = 0; i_gap = 1'b0;
    d_left = 0; d_ntx = 0; d_gap = 1'b0;
    mem_force = 1'b0;
  endtask

  task automatic do_reset();
    to_drive();
    Reset = 1'b1;
    clear_reqs();
    to_drive();
    Reset = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  int exp3[19] = '{0,2,2,0,1,1,0,2,2,0,1,1,0,2,2,0,1,1,0};
  int exp4[15] = '{0,2,2,2,2,0,1,1,0,2,2,2,2,2,0};

  initial begin
    int n2, d0;

    // 1: reset with random requests
    Reset = 1'b1;
    i_left = $urandom_range(0, 1); d_left = $urandom_range(0, 1);
    i_addr = $urandom; d_addr = $urandom; i_we = 1'b1; d_we = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("t1_owner",  bus.Owner,  2'b00);
      check("t1_mreq",   bus.MReq,   1'b0);
      check("t1_mwe",    bus.MWE,    1'b0);
      check("t1_iready", bus.IReady, 1'b0);
      check("t1_dready", bus.DReady, 1'b0);
    end
    to_drive();
    Reset = 1'b0;
    clear_reqs();
    mem_force = 1'b1;
    @(negedge CLK);
    check("idle_mready_iready", bus.IReady, 1'b0);
    check("idle_mready_dready", bus.DReady, 1'b0);
    to_drive();
    mem_force = 1'b0;

    // 2: single D write beat, 1-cycle memory
    to_drive();
    mem_lat = 0;
    req_d(1, 1, 32'h10, 1'b1, 32'hE);
    @(negedge CLK);
    check("t2_grant_cycle_owner", bus.Owner, 2'b00);
    @(negedge CLK);
    check("t2_owner",  bus.Owner,  2'b10);
    check("t2_maddr",  bus.MAddr,  32'h10);
    check("t2_mwe",    bus.MWE,    1'b1);
    check("t2_mwd",    bus.MWD,    32'hE);
    check("t2_dready", bus.DReady, 1'b1);
    check("t2_iready", bus.IReady, 1'b0);
    run_cycles(3);

    // 3: both sides, single-beat transactions, three rounds each
    do_reset();
    trace.delete();
    req_i(1, 3, 32'h100, 1'b0, 32'h0);
    req_d(1, 3, 32'h200, 1'b1, 32'h55);
    run_cycles(19);
    check("t3_len", trace.size(), 19);
    for (int k = 0; k < 19 && k < trace.size(); k++) check("t3_owner_seq", trace[k], exp3[k]);

    // 4: D burst of 8 with I waiting; preempt after beat 4
    do_reset();
    trace.delete(); atrace.delete();
    req_d(8, 1, 32'h300, 1'b0, 32'h0);
    req_i(1, 1, 32'h400, 1'b1, 32'h77);
    run_cycles(15);
    check("t4_len", trace.size(), 15);
    for (int k = 0; k < 15 && k < trace.size(); k++) check("t4_owner_seq", trace[k], exp4[k]);
    if (atrace.size() >= 10) begin
      check("t4_i_addr", atrace[6], 32'h400);
      check("t4_beat5_addr", atrace[9], 32'h304);
    end else begin
      check("t4_atrace_len", atrace.size(), 15);
    end

    // 5: uncontested D burst of 8, 2-cycle memory beats
    do_reset();
    mem_lat = 1;
    trace.delete();
    d0 = d_rdy_n;
    req_d(8, 1, 32'h500, 1'b0, 32'h0);
    run_cycles(19);
    n2 = 0;
    foreach (trace[k]) if (trace[k] == 2) n2++;
    check("t5_busy_cycles", n2, 17);
    check("t5_first", trace[0], 0);
    check("t5_last", trace[trace.size() - 1], 0);
    check("t5_dready_count", d_rdy_n - d0, 8);

    // 6: reset while I owns the port and memory is ready
    do_reset();
    mem_lat = 0;
    req_i(8, 1, 32'h600, 1'b1, 32'h99);
    @(negedge CLK);
    @(negedge CLK);
    check("t6_owner_before", bus.Owner, 2'b01);
    to_drive();
    Reset = 1'b1;
    mem_force = 1'b1;
    @(negedge CLK);
    check("t6_in_reset_iready", bus.IReady, 1'b0);
    to_drive();
    Reset = 1'b0;
    i_left = 0; i_ntx = 0; i_gap = 1'b0;
    @(negedge CLK);
    check("t6_owner", bus.Owner,  2'b00);
    check("t6_mwe",   bus.MWE,    1'b0);
    check("t6_mreq",  bus.MReq,   1'b0);
    check("t6_iready", bus.IReady, 1'b0);
    to_drive();
    mem_force = 1'b0;
    run_cycles(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
